serial_twos_neg: RTL and testbench
==================================

SERIAL_TWOS_NEG -- requirements
Module: serial_twos_neg

Interface
REQ-001 Parameter: W, default 8, word length in bits, legal range 2..32.
REQ-002 Port: t_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: r  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  in_bit/in_sof/mode are valid this cycle; bit consumed.
REQ-005 Port: in_bit  input  1  serial data, LSB first.
REQ-006 Port: in_sof  input  1  marks the LSB (first bit) of a word.
REQ-007 Port: mode  input  2  00 PASS, 01 NEG, 10 ABS, 11 reserved (treated as PASS).
REQ-008 Port: y  output  1  serial result, LSB first; 0 when y_valid=0.
REQ-009 Port: y_valid  output  1  y carries a result bit.
REQ-010 Port: y_last  output  1  y carries the MSB of a result word.
REQ-011 Port: ovf  output  1  negation of -2^(W-1) occurred; asserted only with y_last.

Function
REQ-012 Input framing SHALL use a bit counter 0..W-1. A bit with in_valid=1 and in_sof=1 SHALL load counter position 0 and latch mode for that word.
REQ-013 A bit with in_valid=1 and in_sof=0 SHALL be dropped silently when no word is in progress.
REQ-014 in_sof=1 while a word is in progress SHALL discard the partial word and start a new word at that bit.
REQ-015 Cycles with in_valid=0 SHALL leave all input-side state unchanged; gaps of any length within a word are legal.
REQ-016 Accepted bits SHALL shift into a W-bit input buffer. On acceptance of bit W-1, the buffer, latched mode and sign bit (bit W-1) SHALL transfer to a W-bit output shift register, and the input side returns to idle.
REQ-017 Output FSM SHALL have states IDLE and SHIFT. IDLE->SHIFT on transfer. SHIFT SHALL run exactly W consecutive cycles, then return to IDLE.
REQ-018 A transfer on the last SHIFT cycle SHALL go straight to SHIFT with no idle gap. Overrun is impossible because a word needs at least W input cycles.
REQ-019 First y_valid SHALL occur in the cycle after the edge that accepted bit W-1; latency from MSB acceptance is 1 cycle, and the word appears in W consecutive cycles.
REQ-020 Negate decision: negate = (mode==NEG) or (mode==ABS and sign==1); otherwise bits pass unchanged.
REQ-021 When negating, y SHALL equal the buffered bit XOR seen_one. seen_one clears at the start of each output word and sets after the first buffered 1 has been emitted, so bits up to and including the first 1 pass and later bits invert.
REQ-022 y_last SHALL be 1 on output cycle W-1 only.
REQ-023 ovf SHALL be 1 on the y_last cycle when negate=1 and the word equals 1 followed by W-1 zeros; the emitted result is the same value.
REQ-024 Negating an all-zero word SHALL yield all zeros with ovf=0.
REQ-025 All outputs SHALL be registered with no combinational path from inputs to outputs.

Reset
REQ-026 While r=1, the module SHALL clear the bit counter, input buffer, output shift register, seen_one, FSM (IDLE) and all word-in-progress state, and hold y=0, y_valid=0, y_last=0, ovf=0.
REQ-027 Reset asserted mid-word or mid-SHIFT SHALL abort that word with no further output bits. After release, the first bit is accepted only with in_sof=1.

Verification (W=8, words given as hex values)
REQ-028 NEG 0x05 streamed contiguously -> y_valid for 8 cycles starting 1 cycle after the MSB; output 0xFB; y_last on cycle 8; ovf=0.
REQ-029 ABS 0xFB then, back-to-back, ABS 0x05 -> outputs 0x05 then 0x05 over 16 contiguous y_valid cycles; PASS 0xA3 -> 0xA3.
REQ-030 NEG 0x80 and ABS 0x80 -> output 0x80 with ovf=1 on the y_last cycle. NEG 0x00 -> 0x00 with ovf=0.
REQ-031 NEG 0x5A with in_valid low for 3 cycles between bits 3 and 4 -> output 0xA6, emitted starting 1 cycle after the MSB.
REQ-032 Framing: 4 bits of a word, then in_sof with NEG 0x01 -> only 0xFF is emitted. Bits sent without any preceding in_sof -> no y_valid.
REQ-033 Reset: r pulsed during cycle 3 of SHIFT -> y_valid drops at once with no further bits. After release, a full NEG 0x02 word -> 0xFE.

Source files
------------

// File: rtl/serial_twos_neg.sv
// serial_twos_neg: LSB-first serial PASS/NEG/ABS of W-bit two's-complement words.
module serial_twos_neg #(
  parameter int W = 8
) (
  input  logic       t_clk,
  input  logic       r,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_sof,
  input  logic [1:0] mode,
  output logic       y,
  output logic       y_valid,
  output logic       y_last,
  output logic       ovf
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic busy, busy_n, neg, neg_n, seen, seen_n, ovf_w, ovf_w_n;
  logic acc, xfer, last, run, neg_in, y_n, yv_n, yl_n, ovf_n;
  logic [CW-1:0] cnt, cnt_n, ocnt, ocnt_n, idx;
  logic [W-1:0] ibuf, ibuf_n, osr, osr_n, word;
  logic [1:0] m, m_n;
  always_comb begin
    acc = in_valid && (in_sof || busy);
    idx = in_sof ? '0 : cnt;
    xfer = acc && idx == LAST;
    word = {in_bit, ibuf[W-1:1]};
    neg_in = m == 2'b01 || (m == 2'b10 && in_bit);
    last = state == SHIFT && ocnt == LAST;
    run = state == SHIFT && !last;
    m_n = acc && in_sof ? mode : m;
    busy_n = acc ? !xfer : busy;
    cnt_n = acc ? (xfer ? '0 : idx + CW'(1)) : cnt;
    ibuf_n = acc ? word : ibuf;
    state_n = xfer ? SHIFT : last ? IDLE : state;
    ocnt_n = xfer ? '0 : run ? ocnt + CW'(1) : ocnt;
    osr_n = xfer ? word >> 1 : run ? osr >> 1 : osr;
    neg_n = xfer ? neg_in : neg;
    // seen tracks whether a 1 has already been emitted in this word
    seen_n = xfer ? word[0] : run ? seen | osr[0] : seen;
    ovf_w_n = xfer ? neg_in && word == MIN : ovf_w;
    y_n = xfer ? word[0] : run && (osr[0] ^ (neg & seen));
    yv_n = xfer || run;
    yl_n = run && ocnt + CW'(1) == LAST;
    ovf_n = yl_n && ovf_w;
  end
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state <= IDLE;
      busy <= 1'b0;
      cnt <= '0;
      ocnt <= '0;
      ibuf <= '0;
      osr <= '0;
      m <= '0;
      neg <= 1'b0;
      seen <= 1'b0;
      ovf_w <= 1'b0;
      y <= 1'b0;
      y_valid <= 1'b0;
      y_last <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      busy <= busy_n;
      cnt <= cnt_n;
      ocnt <= ocnt_n;
      ibuf <= ibuf_n;
      osr <= osr_n;
      m <= m_n;
      neg <= neg_n;
      seen <= seen_n;
      ovf_w <= ovf_w_n;
      y <= y_n;
      y_valid <= yv_n;
      y_last <= yl_n;
      ovf <= ovf_n;
    end
  end
endmodule

// File: tb/tb_serial_twos_neg.sv
// tb_serial_twos_neg: directed vectors with a queue scoreboard and decoupled output monitor.
module tb_serial_twos_neg;
  logic t_clk = 0, r = 1, in_valid = 0, in_bit = 0, in_sof = 0;
  logic [1:0] mode = 0;
  logic y, y_valid, y_last, ovf;
  int total = 0, bad = 0, cyc = 0, nb = 0, st = 0;
  logic ign = 0;
  logic [7:0] acc;
  typedef struct {logic [7:0] w; logic o; int st;} exp_t;
  exp_t q[$];

  serial_twos_neg #(.W(8)) dut (.t_clk(t_clk), .r(r), .in_valid(in_valid), .in_bit(in_bit),
    .in_sof(in_sof), .mode(mode), .y(y), .y_valid(y_valid), .y_last(y_last), .ovf(ovf));

  always #5 t_clk = ~t_clk;
  always @(posedge t_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  always @(negedge t_clk) begin
    if (r || ign) nb = 0;
    else begin
      if (!y_valid) check("y_idle_zero", {y, y_last, ovf}, 0);
      if (ovf && !y_last) check("ovf_without_last", 1, 0);
      if (y_valid) begin
        if (nb == 0) st = cyc;
        if (nb < 8) acc[nb] = y;
        nb++;
        if (y_last) begin
          if (q.size() == 0) check("unexpected_word", 1, 0);
          else begin
            exp_t e;
            e = q.pop_front();
            check("word", acc, e.w);
            check("ovf", ovf, e.o);
            check("start_cycle", st, e.st);
            check("bit_count", nb, 8);
          end
          nb = 0;
        end else if (nb > 8) begin
          check("missing_last", nb, 8);
          nb = 0;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic b, input logic s, input logic [1:0] md);
    in_valid = v; in_bit = b; in_sof = s; mode = md;
    @(posedge t_clk); #1;
    in_valid = 0; in_sof = 0;
  endtask

  task automatic send_word(input logic [1:0] md, input logic [7:0] val, input logic [7:0] ew,
                           input logic eo, input int gpos, input int glen);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      drive(1, val[i], i == 0, md);
      if (i == gpos) repeat (glen) drive(0, 0, 0, md);
    end
    e.w = ew; e.o = eo; e.st = cyc;
    if (!ign) q.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge t_clk);
    #1 check("reset_outputs", {y, y_valid, y_last, ovf}, 0);
    r = 0;
    @(posedge t_clk); #1;
    send_word(2'b01, 8'h05, 8'hFB, 0, -1, 0);
    repeat (10) drive(0, 0, 0, 0);
    send_word(2'b10, 8'hFB, 8'h05, 0, -1, 0);
    send_word(2'b10, 8'h05, 8'h05, 0, -1, 0);
    send_word(2'b00, 8'hA3, 8'hA3, 0, -1, 0);
    send_word(2'b01, 8'h80, 8'h80, 1, -1, 0);
    send_word(2'b10, 8'h80, 8'h80, 1, -1, 0);
    send_word(2'b01, 8'h00, 8'h00, 0, -1, 0);
    send_word(2'b11, 8'h3C, 8'h3C, 0, -1, 0);
    send_word(2'b00, 8'h80, 8'h80, 0, -1, 0);
    send_word(2'b01, 8'h5A, 8'hA6, 0, 3, 3);
    repeat (10) drive(0, 0, 0, 0);
    drive(1, 1, 1, 2'b01);
    for (int i = 0; i < 3; i++) drive(1, i[0], 0, 2'b01);
    send_word(2'b01, 8'h01, 8'hFF, 0, -1, 0);
    repeat (10) drive(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(1, 1, 0, 2'b01);
    repeat (12) drive(0, 0, 0, 0);
    ign = 1;
    send_word(2'b01, 8'h33, 8'h00, 0, -1, 0);
    repeat (2) begin @(posedge t_clk); #1; end
    #2 r = 1;
    #1 check("reset_abort", {y, y_valid, y_last, ovf}, 0);
    @(posedge t_clk); #1;
    r = 0; ign = 0;
    repeat (4) drive(1, 1, 0, 2'b01);
    check("no_output_after_reset", y_valid, 0);
    send_word(2'b01, 8'h02, 8'hFE, 0, -1, 0);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge t_clk);
    repeat (4) @(posedge t_clk);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
